pipe_hazard_ctrl: RTL and testbench

- Parametrised hazard, bypass and stall controller for the 5-stage pipeline (IM, ID, EX, DM, WB).
- Generalises the fixed 2-port, 16-register bypass and stall decode to NRP read ports and 2^AW registers.
- Adds load-use interlock, DM wait-state freeze and flush on flow change.
- Tracks in-flight destination writes in EX and DM internally; drives the stall, bubble, flush and bypass selects to the PC, the pipeline registers and the source mux.

---
 rtl/pipe_hazard_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard, bypass and stall controller for a 5-stage pipeline (IM, ID, EX, DM, WB).
//   The block keeps its own copy of the destination write carried by the
//   instructions in EX and DM. It compares the ID instruction's read ports
//   against those writes, then drives the source-mux bypass selects and the
//   stall, bubble and flush controls.
//
//   Parameters
//     AW  : register address width (2^AW registers)
//     NRP : read ports per instruction
//
//   Ports
//     clk, rst          : clock, synchronous active-high reset
//     id_valid          : ID holds a real instruction
//     id_re/id_raddr    : per-port read enable and address (port i at [i*AW +: AW])
//     id_we/id_waddr    : ID destination write
//     id_ld             : ID instruction is a load
//     flow_change_ID_EX : taken branch/jump resolved in EX
//     dm_wait           : data memory not ready; freezes the whole pipe
//     stall_*           : hold PC / pipeline registers
//     bubble_ID_EX      : load a NOP into ID/EX
//     flush_IM_ID       : load a NOP into IM/ID
//     byp_EX / byp_DM   : per-port bypass from the EX / DM result
//
//   Optional build macro
//     PIPE_HAZARD_R0_ZERO_EN : register 0 is hardwired zero and never matches.
//
//   Outputs are combinational from the tracked EX/DM state and the ID inputs.
//   The outputs have no valid/ready handshake. They are level controls that
//   apply to the current cycle.
module pipe_hazard_ctrl #(
  parameter int AW  = 4,
  parameter int NRP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [NRP-1:0]    id_re,
  input  logic [NRP*AW-1:0] id_raddr,
  input  logic              id_we,
  input  logic [AW-1:0]     id_waddr,
  input  logic              id_ld,
  input  logic              flow_change_ID_EX,
  input  logic              dm_wait,
  output logic              stall_pc,
  output logic              stall_IM_ID,
  output logic              stall_ID_EX,
  output logic              stall_EX_DM,
  output logic              bubble_ID_EX,
  output logic              flush_IM_ID,
  output logic [NRP-1:0]    byp_EX,
  output logic [NRP-1:0]    byp_DM
);

  // Per-cycle action chosen from the priority rst > dm_wait > flow change > load-use.
  typedef enum logic [2:0] {
    ACT_NORMAL   = 3'd0,
    ACT_LOAD_USE = 3'd1,
    ACT_FLUSH    = 3'd2,
    ACT_WAIT     = 3'd3,
    ACT_RESET    = 3'd4
  } act_e;

  logic          ex_v_q, ex_we_q, ex_ld_q;
  logic [AW-1:0] ex_wa_q;
  logic          dm_v_q, dm_we_q;
  logic [AW-1:0] dm_wa_q;

  logic          ex_v_d, ex_we_d, ex_ld_d;
  logic [AW-1:0] ex_wa_d;
  logic          dm_v_d, dm_we_d;
  logic [AW-1:0] dm_wa_d;

  logic [NRP-1:0] m_ex;
  logic [NRP-1:0] m_dm;
  logic           lu;
  act_e           act;

  // Read-port matches against the in-flight writes.
  for (genvar i = 0; i < NRP; i++) begin : g_match
    logic [AW-1:0] raddr;
    logic          rd_ok;
    assign raddr = id_raddr[i*AW +: AW];
`ifdef PIPE_HAZARD_R0_ZERO_EN
    // r0 reads always return zero from the RF, so they never need a producer.
    // A nonzero raddr that equals wa also implies wa is nonzero.
    assign rd_ok = id_valid & id_re[i] & (raddr != '0);
`else
    assign rd_ok = id_valid & id_re[i];
`endif
    assign m_ex[i] = rd_ok & ex_v_q & ex_we_q & (raddr == ex_wa_q);
    assign m_dm[i] = rd_ok & dm_v_q & dm_we_q & (raddr == dm_wa_q);
  end

  // A load in EX has no data until DM, so a match on it needs one interlock cycle.
  assign lu = |(m_ex & {NRP{ex_ld_q}});

  always_comb begin
    act = ACT_NORMAL;
    if (rst)                    act = ACT_RESET;
    else if (dm_wait)           act = ACT_WAIT;
    else if (flow_change_ID_EX) act = ACT_FLUSH;
    else if (lu)                act = ACT_LOAD_USE;
  end

  // Control outputs.
  always_comb begin
    stall_pc     = 1'b0;
    stall_IM_ID  = 1'b0;
    stall_ID_EX  = 1'b0;
    stall_EX_DM  = 1'b0;
    bubble_ID_EX = 1'b0;
    flush_IM_ID  = 1'b0;
    byp_EX       = '0;
    byp_DM       = '0;
    if (act != ACT_RESET) begin
      // The youngest producer wins. A load in EX bypasses nothing.
      byp_EX = m_ex & ~{NRP{ex_ld_q}};
      byp_DM = m_dm & ~m_ex;
    end
    case (act)
      ACT_WAIT: begin
        stall_pc    = 1'b1;
        stall_IM_ID = 1'b1;
        stall_ID_EX = 1'b1;
        stall_EX_DM = 1'b1;
      end
      ACT_FLUSH: begin
        flush_IM_ID  = 1'b1;
        bubble_ID_EX = 1'b1;
      end
      ACT_LOAD_USE: begin
        stall_pc     = 1'b1;
        stall_IM_ID  = 1'b1;
        bubble_ID_EX = 1'b1;
      end
      default: ;
    endcase
  end

  // Tracked-state next value.
  always_comb begin
    ex_v_d  = ex_v_q;
    ex_we_d = ex_we_q;
    ex_wa_d = ex_wa_q;
    ex_ld_d = ex_ld_q;
    dm_v_d  = dm_v_q;
    dm_we_d = dm_we_q;
    dm_wa_d = dm_wa_q;
    case (act)
      ACT_RESET: begin
        ex_v_d  = 1'b0;
        ex_we_d = 1'b0;
        ex_wa_d = '0;
        ex_ld_d = 1'b0;
        dm_v_d  = 1'b0;
        dm_we_d = 1'b0;
        dm_wa_d = '0;
      end
      ACT_WAIT: ;  // whole pipe frozen
      ACT_FLUSH, ACT_LOAD_USE: begin
        // EX advances to DM, and a bubble enters EX.
        dm_v_d  = ex_v_q;
        dm_we_d = ex_we_q;
        dm_wa_d = ex_wa_q;
        ex_v_d  = 1'b0;
        ex_we_d = 1'b0;
        ex_wa_d = '0;
        ex_ld_d = 1'b0;
      end
      default: begin
        dm_v_d  = ex_v_q;
        dm_we_d = ex_we_q;
        dm_wa_d = ex_wa_q;
        ex_v_d  = id_valid;
        ex_we_d = id_we;
        ex_wa_d = id_waddr;
        ex_ld_d = id_ld;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // The reset values come from ACT_RESET in the next-state logic.
    ex_v_q  <= ex_v_d;
    ex_we_q <= ex_we_d;
    ex_wa_q <= ex_wa_d;
    ex_ld_q <= ex_ld_d;
    dm_v_q  <= dm_v_d;
    dm_we_q <= dm_we_d;
    dm_wa_q <= dm_wa_d;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl.
//   It drives directed instruction sequences through ID. A behavioural model
//   tracks the instructions in flight and checks every output on every falling
//   edge. Hand-computed literal checks pin the key scenarios.
module tb_pipe_hazard_ctrl;
  localparam int AW  = 4;
  localparam int NRP = 2;

  logic              clk;
  logic              rst;
  logic              id_valid;
  logic [NRP-1:0]    id_re;
  logic [NRP*AW-1:0] id_raddr;
  logic              id_we;
  logic [AW-1:0]     id_waddr;
  logic              id_ld;
  logic              flow_change_ID_EX;
  logic              dm_wait;
  logic              stall_pc, stall_IM_ID, stall_ID_EX, stall_EX_DM;
  logic              bubble_ID_EX, flush_IM_ID;
  logic [NRP-1:0]    byp_EX, byp_DM;

  int total = 0;
  int bad   = 0;

  pipe_hazard_ctrl #(.AW(AW), .NRP(NRP)) dut (
    .clk               (clk),
    .rst               (rst),
    .id_valid          (id_valid),
    .id_re             (id_re),
    .id_raddr          (id_raddr),
    .id_we             (id_we),
    .id_waddr          (id_waddr),
    .id_ld             (id_ld),
    .flow_change_ID_EX (flow_change_ID_EX),
    .dm_wait           (dm_wait),
    .stall_pc          (stall_pc),
    .stall_IM_ID       (stall_IM_ID),
    .stall_ID_EX       (stall_ID_EX),
    .stall_EX_DM       (stall_EX_DM),
    .bubble_ID_EX      (bubble_ID_EX),
    .flush_IM_ID       (flush_IM_ID),
    .byp_EX            (byp_EX),
    .byp_DM            (byp_DM)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Instructions in flight, youngest first: slot 0 = EX, slot 1 = DM.
  typedef struct {
    bit          v;
    bit          we;
    logic [AW-1:0] wa;
    bit          ld;
  } ins_t;

  ins_t pipe_m[2];

  logic [3:0]     e_stall;  // {pc, IM_ID, ID_EX, EX_DM}
  logic           e_bub, e_flush, e_lu;
  logic [NRP-1:0] e_bex, e_bdm;

  function automatic bit reads_real(input logic [AW-1:0] a);
`ifdef PIPE_HAZARD_R0_ZERO_EN
    return a != 0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_eval();
    e_stall = 4'b0000; e_bub = 0; e_flush = 0; e_lu = 0;
    e_bex = '0; e_bdm = '0;
    // Each port takes the value from the youngest in-flight writer of its register.
    for (int p = 0; p < NRP; p++) begin
      logic [AW-1:0] a;
      a = id_raddr[p*AW +: AW];
      if (id_valid && id_re[p] && reads_real(a)) begin
        for (int k = 0; k < 2; k++) begin
          if (pipe_m[k].v && pipe_m[k].we && pipe_m[k].wa == a) begin
            if (k == 0 && pipe_m[k].ld) e_lu = 1;
            else if (k == 0)            e_bex[p] = 1'b1;
            else                        e_bdm[p] = 1'b1;
            break;
          end
        end
      end
    end
    if (rst) begin
      e_bex = '0; e_bdm = '0;
    end else if (dm_wait) begin
      e_stall = 4'b1111;
    end else if (flow_change_ID_EX) begin
      e_flush = 1; e_bub = 1;
    end else if (e_lu) begin
      e_stall = 4'b1100; e_bub = 1;
    end
  endtask

  initial begin
    pipe_m[0] = '{0, 0, 0, 0};
    pipe_m[1] = '{0, 0, 0, 0};
  end

  // Compare process: outputs are checked mid-cycle, away from the active edge.
  always @(negedge clk) begin
    model_eval();
    check("m_stall", {stall_pc, stall_IM_ID, stall_ID_EX, stall_EX_DM}, e_stall);
    check("m_bubble", bubble_ID_EX, e_bub);
    check("m_flush", flush_IM_ID, e_flush);
    check("m_byp_EX", byp_EX, e_bex);
    check("m_byp_DM", byp_DM, e_bdm);
  end

  // Model pipeline advance, using the inputs held over the rising edge.
  always @(posedge clk) begin
    ins_t id_ins;
    model_eval();
    id_ins = '{id_valid, id_we, id_waddr, id_ld};
    if (rst) begin
      pipe_m[0] = '{0, 0, 0, 0};
      pipe_m[1] = '{0, 0, 0, 0};
    end else if (dm_wait) begin
      // frozen
    end else if (flow_change_ID_EX || e_lu) begin
      pipe_m[1] = pipe_m[0];
      pipe_m[0] = '{0, 0, 0, 0};
    end else begin
      pipe_m[1] = pipe_m[0];
      pipe_m[0] = id_ins;
    end
  end

  // ---------------- driver ----------------
  // One call = one cycle. The task returns just after the falling edge, so
  // literal checks that follow it see the settled outputs for that cycle.
  task automatic cyc(input bit v, input logic [1:0] re, input logic [3:0] ra0,
                     input logic [3:0] ra1, input bit we, input logic [3:0] wa,
                     input bit ld, input bit fc, input bit dw, input bit r);
    @(posedge clk);
    #1;
    id_valid = v; id_re = re; id_raddr = {ra1, ra0};
    id_we = we; id_waddr = wa; id_ld = ld;
    flow_change_ID_EX = fc; dm_wait = dw; rst = r;
    @(negedge clk);
    #1;
  endtask

  task automatic nop();
    cyc(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input logic [3:0] wa, input bit ld);
    cyc(1, 2'b00, 0, 0, 1, wa, ld, 0, 0, 0);
  endtask

  task automatic chk_out(input string name, input logic [3:0] st, input bit bub,
                         input bit fl, input logic [1:0] bex, input logic [1:0] bdm);
    check({name, "_stall"}, {stall_pc, stall_IM_ID, stall_ID_EX, stall_EX_DM}, st);
    check({name, "_bubble"}, bubble_ID_EX, bub);
    check({name, "_flush"}, flush_IM_ID, fl);
    check({name, "_bypEX"}, byp_EX, bex);
    check({name, "_bypDM"}, byp_DM, bdm);
  endtask

  initial begin
    rst = 1; id_valid = 0; id_re = 0; id_raddr = 0; id_we = 0; id_waddr = 0;
    id_ld = 0; flow_change_ID_EX = 0; dm_wait = 0;

    // Reset with matching-looking ID traffic: all outputs must stay 0.
    cyc(1, 2'b11, 3, 3, 1, 3, 0, 0, 0, 1);
    cyc(1, 2'b11, 3, 3, 0, 0, 0, 1, 1, 1);
    chk_out("reset", 4'b0000, 0, 0, 2'b00, 2'b00);
    nop(); nop();

    // ALU r3 in EX, ID reads r3 on port 1.
    wr(3, 0);
    cyc(1, 2'b10, 0, 3, 0, 0, 0, 0, 0, 0);
    chk_out("alu_ex", 4'b0000, 0, 0, 2'b10, 2'b00);
    nop(); nop();

    // LW r5 in EX, ID reads r5 on port 0: one interlock, then DM bypass.
    wr(5, 1);
    cyc(1, 2'b01, 5, 0, 0, 0, 0, 0, 0, 0);
    chk_out("lu_c1", 4'b1100, 1, 0, 2'b00, 2'b00);
    cyc(1, 2'b01, 5, 0, 0, 0, 0, 0, 0, 0);
    chk_out("lu_c2", 4'b0000, 0, 0, 2'b00, 2'b01);
    nop(); nop();

    // r7 produced in both EX and DM: the youngest (EX) wins on both ports.
    wr(7, 0);
    wr(7, 0);
    cyc(1, 2'b11, 7, 7, 0, 0, 0, 0, 0, 0);
    chk_out("young", 4'b0000, 0, 0, 2'b11, 2'b00);
    nop(); nop();

    // DM-only producer.
    wr(4, 0);
    nop();
    cyc(1, 2'b10, 0, 4, 0, 0, 0, 0, 0, 0);
    chk_out("dm_only", 4'b0000, 0, 0, 2'b00, 2'b10);
    nop(); nop();

    // LW r2 with flow change under 3 wait cycles, then the flush wins over load-use.
    wr(2, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 2'b01, 2, 0, 0, 0, 0, 1, 1, 0);
      chk_out("wait_fc", 4'b1111, 0, 0, 2'b00, 2'b00);
    end
    cyc(1, 2'b01, 2, 0, 0, 0, 0, 1, 0, 0);
    chk_out("flush", 4'b0000, 1, 1, 2'b00, 2'b00);
    cyc(1, 2'b01, 2, 0, 0, 0, 0, 0, 0, 0);
    chk_out("post_flush", 4'b0000, 0, 0, 2'b00, 2'b01);
    nop(); nop();

    // Bypass stays driven during a wait, and the state holds across it.
    wr(6, 0);
    cyc(1, 2'b01, 6, 0, 0, 0, 0, 0, 1, 0);
    chk_out("wait_byp", 4'b1111, 0, 0, 2'b01, 2'b00);
    cyc(1, 2'b01, 6, 0, 0, 0, 0, 0, 0, 0);
    chk_out("wait_rel", 4'b0000, 0, 0, 2'b01, 2'b00);
    nop(); nop();

    // id_valid=0 never matches.
    wr(9, 1);
    cyc(0, 2'b11, 9, 9, 0, 0, 0, 0, 0, 0);
    chk_out("novalid", 4'b0000, 0, 0, 2'b00, 2'b00);
    nop(); nop();

    // Reset during the load-use cycle discards the stall and the tracked producer.
    wr(2, 1);
    cyc(1, 2'b01, 2, 0, 0, 0, 0, 0, 0, 1);
    chk_out("rst_lu", 4'b0000, 0, 0, 2'b00, 2'b00);
    cyc(1, 2'b01, 2, 0, 0, 0, 0, 0, 0, 0);
    chk_out("after_rst", 4'b0000, 0, 0, 2'b00, 2'b00);
    nop(); nop();

    // r0 producer.
    wr(0, 0);
    cyc(1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef PIPE_HAZARD_R0_ZERO_EN
    chk_out("r0", 4'b0000, 0, 0, 2'b00, 2'b00);
`else
    chk_out("r0", 4'b0000, 0, 0, 2'b01, 2'b00);
`endif
    nop(); nop();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
